sdram_port_arbiter: RTL and testbench

//  Shares the single 16-bit SDRAM controller port among NUM_REQ requesters (mport_manager

---
 rtl/mmu_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 24 ++
 rtl/sdram_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared widths and state encoding for the SDRAM port arbiter.
package mmu_pkg;
    localparam int SDRAM_AW = 23;
    localparam int SDRAM_DW = 16;
    localparam int WORD_W   = 32;
    localparam int WADDR_W  = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_LO,
        ST_WAIT_LO,
        ST_ISSUE_HI,
        ST_WAIT_HI,
        ST_RESP
    } arb_state_t;

    function automatic logic [SDRAM_AW-1:0] half_addr(input logic [WADDR_W-1:0] waddr,
                                                      input logic half);
        return {waddr, half};
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!any_req && req[(int'(ptr) + i) % NUM_REQ]) begin
                any_req = 1'b1;
                grant[(int'(ptr) + i) % NUM_REQ] = 1'b1;
                idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one 16-bit SDRAM controller port among NUM_REQ 32-bit word requesters.
// states: IDLE arbitrate | ISSUE_x strobe half | WAIT_x await done/timeout | RESP report
module sdram_port_arbiter
    import mmu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      SDRAM_pll_locked,
    input  logic                      SDRAM_ready,
    output logic                      SDRAM_as,
    output logic                      SDRAM_rw,
    output logic [SDRAM_AW-1:0]       SDRAM_addr,
    output logic [SDRAM_DW-1:0]       SDRAM_data_write,
    input  logic [SDRAM_DW-1:0]       SDRAM_data_read,
    input  logic                      SDRAM_done,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*WADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WORD_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_done,
    output logic                      rsp_err,
    output logic [WORD_W-1:0]         rsp_rdata
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    arb_state_t           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   cur_oh;
    logic                 cur_rw;
    logic [WADDR_W-1:0]   cur_addr;
    logic [WORD_W-1:0]    cur_wdata;
    logic [SDRAM_DW-1:0]  rd_lo;
    logic [TO_W-1:0]      to_cnt;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 waiting;
    logic                 active;
    logic                 issue_hi;
    logic                 abort;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .any_req (arb_any)
    );

    assign waiting  = (state == ST_WAIT_LO) || (state == ST_WAIT_HI);
    assign issue_hi = (state == ST_ISSUE_HI);
    assign active   = waiting || (state == ST_ISSUE_LO) || issue_hi;
    // Losing the PLL or running the timer out drops the remaining halves.
    assign abort    = active && (!SDRAM_pll_locked || (waiting && !SDRAM_done && to_cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            rr_ptr           <= IDX_W'(NUM_REQ - 1);
            cur_oh           <= '0;
            cur_rw           <= 1'b0;
            cur_addr         <= '0;
            cur_wdata        <= '0;
            rd_lo            <= '0;
            to_cnt           <= '0;
            SDRAM_as         <= 1'b0;
            SDRAM_rw         <= 1'b0;
            SDRAM_addr       <= '0;
            SDRAM_data_write <= '0;
            req_ready        <= '0;
            rsp_done         <= '0;
            rsp_err          <= 1'b0;
            rsp_rdata        <= '0;
        end else begin
            req_ready <= '0;
            SDRAM_as  <= 1'b0;
            rsp_done  <= '0;
            rsp_err   <= 1'b0;
            if (abort) begin
                rsp_done <= cur_oh;
                rsp_err  <= 1'b1;
                state    <= ST_RESP;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (SDRAM_pll_locked && SDRAM_ready && arb_any) begin
                            req_ready <= arb_grant;
                            cur_oh    <= arb_grant;
                            cur_rw    <= req_rw[arb_idx];
                            cur_addr  <= req_addr[arb_idx*WADDR_W +: WADDR_W];
                            cur_wdata <= req_wdata[arb_idx*WORD_W +: WORD_W];
                            rr_ptr    <= arb_idx;
                            state     <= ST_ISSUE_LO;
                        end
                    end
                    ST_ISSUE_LO, ST_ISSUE_HI: begin
                        if (SDRAM_ready) begin
                            SDRAM_as         <= 1'b1;
                            SDRAM_rw         <= cur_rw;
                            SDRAM_addr       <= half_addr(cur_addr, issue_hi);
                            SDRAM_data_write <= issue_hi ? cur_wdata[WORD_W-1:SDRAM_DW]
                                                         : cur_wdata[SDRAM_DW-1:0];
                            to_cnt           <= TO_W'(TIMEOUT - 1);
                            state            <= issue_hi ? ST_WAIT_HI : ST_WAIT_LO;
                        end
                    end
                    ST_WAIT_LO: begin
                        if (SDRAM_done) begin
                            if (cur_rw)
                                rd_lo <= SDRAM_data_read;
                            state <= ST_ISSUE_HI;
                        end else begin
                            to_cnt <= to_cnt - 1'b1;
                        end
                    end
                    ST_WAIT_HI: begin
                        if (SDRAM_done) begin
                            rsp_done <= cur_oh;
                            if (cur_rw)
                                rsp_rdata <= {SDRAM_data_read, rd_lo};
                            state <= ST_RESP;
                        end else begin
                            to_cnt <= to_cnt - 1'b1;
                        end
                    end
                    ST_RESP: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small SDRAM controller model.
module tb_sdram_port_arbiter;
    localparam int NREQ = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          SDRAM_pll_locked = 1'b1;
    logic          SDRAM_ready = 1'b1;
    logic          SDRAM_as;
    logic          SDRAM_rw;
    logic [22:0]   SDRAM_addr;
    logic [15:0]   SDRAM_data_write;
    logic [15:0]   SDRAM_data_read;
    logic          SDRAM_done;
    logic [3:0]    req_valid = '0;
    logic [3:0]    req_rw = '0;
    logic [87:0]   req_addr = '0;
    logic [127:0]  req_wdata = '0;
    logic [3:0]    req_ready;
    logic [3:0]    rsp_done;
    logic          rsp_err;
    logic [31:0]   rsp_rdata;

    sdram_port_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .SDRAM_pll_locked(SDRAM_pll_locked), .SDRAM_ready(SDRAM_ready),
        .SDRAM_as(SDRAM_as), .SDRAM_rw(SDRAM_rw), .SDRAM_addr(SDRAM_addr),
        .SDRAM_data_write(SDRAM_data_write), .SDRAM_data_read(SDRAM_data_read),
        .SDRAM_done(SDRAM_done),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] addr;
        logic        rw;
        logic [15:0] wd;
    } acc_t;

    typedef struct {
        int          port;
        logic        rw;
        logic [21:0] addr;
        logic [31:0] wdata;
        logic [15:0] rd_lo;
        logic [15:0] rd_hi;
        int          lat;
        logic [22:0] exp_a0;
        logic [22:0] exp_a1;
        logic [15:0] exp_w0;
        logic [15:0] exp_w1;
        logic [31:0] exp_rdata;
    } vec_t;

    acc_t        acc_q[$];
    int          grant_q[$];
    int          rsp_n = 0;
    logic [3:0]  last_oh = '0;
    logic        last_err = 1'b0;
    logic [31:0] last_rdata = '0;

    int          model_lat = 1;
    bit          model_hang = 1'b0;
    logic [15:0] model_rd_lo = '0;
    logic [15:0] model_rd_hi = '0;

    int n_chk = 0;
    int n_fail = 0;

    // SDRAM controller model: accepts a strobe, answers after model_lat cycles.
    initial begin
        bit m_busy;
        int m_cnt;
        m_busy = 1'b0;
        m_cnt = 0;
        SDRAM_done = 1'b0;
        SDRAM_data_read = '0;
        forever begin
            @(negedge clk);
            SDRAM_done = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
            end else if (SDRAM_as) begin
                acc_q.push_back('{SDRAM_addr, SDRAM_rw, SDRAM_data_write});
                if (!model_hang) begin
                    m_busy = 1'b1;
                    m_cnt = model_lat;
                end
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    SDRAM_done = 1'b1;
                    SDRAM_data_read = SDRAM_addr[0] ? model_rd_hi : model_rd_lo;
                    m_busy = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int p = 0; p < NREQ; p++)
                    if (req_ready[p]) grant_q.push_back(p);
                if (rsp_done != '0) begin
                    rsp_n++;
                    last_oh = rsp_done;
                    last_err = rsp_err;
                    last_rdata = rsp_rdata;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_req(input int p, input logic rw, input logic [21:0] a, input logic [31:0] wd);
        bit ok;
        ok = 1'b0;
        req_rw[p] = rw;
        req_addr[p*22 +: 22] = a;
        req_wdata[p*32 +: 32] = wd;
        req_valid[p] = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (req_ready[p]) ok = 1'b1;
        end
        req_valid[p] = 1'b0;
        chk($sformatf("grant_wait_p%0d", p), 64'(ok), 64'd1);
    endtask

    task automatic wait_rsp(input int n0);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (rsp_n > n0) ok = 1'b1;
            else tick();
        end
        chk("rsp_wait", 64'(ok), 64'd1);
    endtask

    initial begin
        vec_t vecs[4];
        int   base;
        int   r0;
        int   gn;
        int   k;
        int   as_cnt;
        bit   ok;
        int   exp_order[5];

        vecs[0] = '{0, 1'b0, 22'h000010, 32'hDEADBEEF, 16'h0000, 16'h0000, 1,
                    23'h000020, 23'h000021, 16'hBEEF, 16'hDEAD, 32'h00000000};
        vecs[1] = '{2, 1'b1, 22'h3FFFFF, 32'h00000000, 16'h1234, 16'h5678, 2,
                    23'h7FFFFE, 23'h7FFFFF, 16'h0000, 16'h0000, 32'h56781234};
        vecs[2] = '{1, 1'b0, 22'h155555, 32'h0F0FA5A5, 16'h0000, 16'h0000, 1,
                    23'h2AAAAA, 23'h2AAAAB, 16'hA5A5, 16'h0F0F, 32'h56781234};
        vecs[3] = '{3, 1'b1, 22'h000000, 32'h00000000, 16'hFFFF, 16'h0001, 3,
                    23'h000000, 23'h000001, 16'h0000, 16'h0000, 32'h0001FFFF};
        exp_order = '{0, 1, 2, 3, 0};

        repeat (3) tick();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_done", 64'(rsp_done), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_as", 64'(SDRAM_as), 64'd0);
        chk("rst_addr", 64'(SDRAM_addr), 64'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            model_lat = vecs[v].lat;
            model_rd_lo = vecs[v].rd_lo;
            model_rd_hi = vecs[v].rd_hi;
            base = acc_q.size();
            r0 = rsp_n;
            start_req(vecs[v].port, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
            wait_rsp(r0);
            chk($sformatf("v%0d_acc_count", v), 64'(acc_q.size() - base), 64'd2);
            chk($sformatf("v%0d_addr_lo", v), 64'(acc_q[base].addr), 64'(vecs[v].exp_a0));
            chk($sformatf("v%0d_addr_hi", v), 64'(acc_q[base+1].addr), 64'(vecs[v].exp_a1));
            chk($sformatf("v%0d_rw_lo", v), 64'(acc_q[base].rw), 64'(vecs[v].rw));
            chk($sformatf("v%0d_rw_hi", v), 64'(acc_q[base+1].rw), 64'(vecs[v].rw));
            if (!vecs[v].rw) begin
                chk($sformatf("v%0d_wdata_lo", v), 64'(acc_q[base].wd), 64'(vecs[v].exp_w0));
                chk($sformatf("v%0d_wdata_hi", v), 64'(acc_q[base+1].wd), 64'(vecs[v].exp_w1));
            end
            chk($sformatf("v%0d_rsp_port", v), 64'(last_oh), 64'(4'b0001 << vecs[v].port));
            chk($sformatf("v%0d_rsp_err", v), 64'(last_err), 64'd0);
            chk($sformatf("v%0d_rsp_rdata", v), 64'(last_rdata), 64'(vecs[v].exp_rdata));
            tick();
            chk($sformatf("v%0d_rsp_pulse", v), 64'(rsp_done), 64'd0);
        end

        // SDRAM_ready held low while the high half waits to be strobed
        model_lat = 1;
        base = acc_q.size();
        r0 = rsp_n;
        start_req(1, 1'b0, 22'h0ABCDE, 32'h11112222);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (SDRAM_done) ok = 1'b1;
        end
        chk("s4_lo_done", 64'(ok), 64'd1);
        SDRAM_ready = 1'b0;
        as_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (SDRAM_as) as_cnt++;
        end
        chk("s4_as_held_low", 64'(as_cnt), 64'd0);
        chk("s4_acc_before", 64'(acc_q.size() - base), 64'd1);
        SDRAM_ready = 1'b1;
        tick();
        chk("s4_as_pulse", 64'(SDRAM_as), 64'd1);
        chk("s4_hi_addr", 64'(SDRAM_addr), 64'h1579BD);
        chk("s4_hi_wdata", 64'(SDRAM_data_write), 64'h1111);
        tick();
        chk("s4_as_single", 64'(SDRAM_as), 64'd0);
        wait_rsp(r0);
        chk("s4_rsp_port", 64'(last_oh), 64'b0010);
        chk("s4_rsp_err", 64'(last_err), 64'd0);
        chk("s4_acc_count", 64'(acc_q.size() - base), 64'd2);

        // controller never answers: timeout after 16 WAIT cycles
        model_hang = 1'b1;
        base = acc_q.size();
        r0 = rsp_n;
        start_req(3, 1'b1, 22'h2AAAAA, 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (acc_q.size() > base) ok = 1'b1;
        end
        chk("s5_strobe", 64'(ok), 64'd1);
        k = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            k++;
            if (rsp_done != '0) ok = 1'b1;
        end
        chk("s5_timeout_cycles", 64'(k), 64'd16);
        chk("s5_rsp_port", 64'(rsp_done), 64'b1000);
        chk("s5_rsp_err", 64'(rsp_err), 64'd1);
        chk("s5_rdata_kept", 64'(rsp_rdata), 64'h0001FFFF);
        chk("s5_no_hi_half", 64'(acc_q.size() - base), 64'd1);
        model_hang = 1'b0;
        model_lat = 2;
        model_rd_lo = 16'hCAFE;
        model_rd_hi = 16'hBABE;
        base = acc_q.size();
        r0 = rsp_n;
        start_req(0, 1'b1, 22'h000100, 32'h0);
        wait_rsp(r0);
        chk("s5_after_err", 64'(last_err), 64'd0);
        chk("s5_after_rdata", 64'(last_rdata), 64'hBABECAFE);
        chk("s5_after_addr_lo", 64'(acc_q[base].addr), 64'h000200);

        // PLL loss during WAIT_LO, then no grant until relock
        model_lat = 8;
        base = acc_q.size();
        r0 = rsp_n;
        start_req(2, 1'b0, 22'h000033, 32'h89ABCDEF);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (acc_q.size() > base) ok = 1'b1;
        end
        chk("s6_strobe", 64'(ok), 64'd1);
        SDRAM_pll_locked = 1'b0;
        wait_rsp(r0);
        chk("s6_rsp_port", 64'(last_oh), 64'b0100);
        chk("s6_rsp_err", 64'(last_err), 64'd1);
        chk("s6_rdata_kept", 64'(last_rdata), 64'hBABECAFE);
        chk("s6_no_hi_half", 64'(acc_q.size() - base), 64'd1);
        gn = grant_q.size();
        req_rw[0] = 1'b0;
        req_valid[0] = 1'b1;
        repeat (10) tick();
        chk("s6_no_grant_unlocked", 64'(grant_q.size() - gn), 64'd0);
        SDRAM_pll_locked = 1'b1;
        model_lat = 2;
        r0 = rsp_n;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (req_ready[0]) ok = 1'b1;
        end
        req_valid[0] = 1'b0;
        chk("s6_grant_relock", 64'(ok), 64'd1);
        wait_rsp(r0);
        chk("s6_relock_port", 64'(last_oh), 64'b0001);
        chk("s6_relock_err", 64'(last_err), 64'd0);

        // reset mid-transaction, then all ports requesting continuously
        model_lat = 4;
        base = acc_q.size();
        start_req(1, 1'b0, 22'h000777, 32'h55AA55AA);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (acc_q.size() > base) ok = 1'b1;
        end
        chk("s7_strobe", 64'(ok), 64'd1);
        r0 = rsp_n;
        rst = 1'b1;
        req_rw = 4'b0000;
        req_valid = 4'b1111;
        tick();
        chk("s7_rst_req_ready", 64'(req_ready), 64'd0);
        chk("s7_rst_rsp_done", 64'(rsp_done), 64'd0);
        chk("s7_rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("s7_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("s7_rst_as", 64'(SDRAM_as), 64'd0);
        chk("s7_rst_rw", 64'(SDRAM_rw), 64'd0);
        chk("s7_rst_addr", 64'(SDRAM_addr), 64'd0);
        chk("s7_rst_wdata", 64'(SDRAM_data_write), 64'd0);
        repeat (3) tick();
        chk("s7_no_rsp_on_rst", 64'(rsp_n - r0), 64'd0);
        model_lat = 1;
        gn = grant_q.size();
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (grant_q.size() >= gn + 5) ok = 1'b1;
        end
        req_valid = 4'b0000;
        chk("s7_five_grants", 64'(ok), 64'd1);
        for (int i = 0; i < 5; i++)
            chk($sformatf("s7_grant_order_%0d", i), 64'(grant_q[gn+i]), 64'(exp_order[i]));
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (rsp_n >= r0 + 5) ok = 1'b1;
            else tick();
        end
        chk("s7_five_rsps", 64'(rsp_n - r0), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
